memory_access: RTL and testbench
================================

# memory_access

Fourth pipeline stage of the in-order RV64 core. Consumes the registered control/result bundle from the execute stage. Performs loads, stores and fences over a single-outstanding 64-bit data bus with a request/acknowledge handshake, and resolves branches against the prediction. Registers the writeback bundle for the final stage and holds the pipe while a bus access is in flight.

## Interface
- No parameters; XLEN fixed at 64.
- Clock/reset (already decided): one clock, `clk`; reset `rst_n`, asynchronous, active-low.
- `clk  in  1  core clock, all state on rising edge`
- `rst_n  in  1  asynchronous active-low reset`
- `stall_in  in  1  downstream/hazard hold; output registers keep value`
- `flush_in  in  1  squash instruction in this stage`
- `valid_in  in  1  instruction valid`
- `branch_predicted_taken_in  in  1  fetch prediction`
- `alu_non_zero_in  in  1  ALU result non-zero (branch condition)`
- `mem_read_in, mem_write_in, mem_fence_in  in  1 each  access type`
- `mem_width_in  in  3  0=byte 1=half 2=word 3=double`
- `mem_zero_extend_in  in  1  zero-extend load (else sign-extend)`
- `branch_op_in  in  3  0=none 1=always 2=if non-zero 3=if zero`
- `rd_in  in  9 ; rd_write_in  in  1  destination`
- `pc_in, result_in, rs2_value_in, branch_pc_in  in  64 each  PC, ALU result/address, store data, branch target`
- `data_req_out  out  1 ; data_we_out  out  1 ; data_addr_out  out  64 (8-byte aligned) ; data_wdata_out  out  64 ; data_strb_out  out  8`
- `data_ack_in  in  1 ; data_rdata_in  in  64`
- `busy_out  out  1  combinational stall request to upstream`
- `redirect_out  out  1 ; redirect_pc_out  out  64  combinational mispredict redirect`
- `misaligned_out  out  1  registered fault pulse`
- `valid_out, rd_write_out  out  1 ; rd_out  out  9 ; rd_value_out  out  64  writeback bundle`

## Operation
- Access op = `valid_in & (mem_read_in | mem_write_in) & !flush_in`.
- FSM states:
  - IDLE: access op, aligned, no fence → WAIT at next edge. Misaligned → no bus access; `misaligned_out`=1 for one cycle, writeback `rd_write_out`=0.
  - WAIT: `data_req_out`=1 with address/data/strobe held stable until `data_ack_in`. On ack: load data captured into `rd_value_out`; next state IDLE if `!stall_in`, else DONE.
  - DONE: result held, no new request; → IDLE at first edge with `!stall_in`.
- `busy_out` = (IDLE & access op & aligned) | (WAIT & !data_ack_in).
- Alignment: half needs addr[0]=0; word needs addr[1:0]=0; double needs addr[2:0]=0.
- Byte lane = addr[2:0]. Store data replicated to the lane. Strobes: byte 1<<lane, half 3<<lane, word F<<lane, double FF.
- Load: shift `data_rdata_in` right by lane*8, truncate to width, zero- or sign-extend per `mem_zero_extend_in`. Width codes 4–7 are treated as double.
- Fence completes in IDLE with no bus cycle; the bus is blocking, so ordering is inherent.
- Branch: taken = op1 | (op2 & nz) | (op3 & !nz).
  - `redirect_out` = `valid_in & !flush_in & branch_op_in!=0 & taken != branch_predicted_taken_in`.
  - `redirect_pc_out` = taken ? `branch_pc_in` : `pc_in`+4.
- Writeback register loads when `!stall_in & !busy_out`:
  - `valid_out` = `valid_in`
  - `rd_value_out` = load data if read, else `result_in`.
  - `flush_in` or misaligned forces `valid_out`/`rd_write_out` to 0.
- `flush_in` in WAIT does not abort the bus transaction. It completes, but the result is discarded.

## Timing
- Reset: state IDLE. `data_req_out`, `data_we_out`, `busy_out`, `misaligned_out`, `valid_out`, `rd_write_out` = 0. All 64-bit outputs, `data_strb_out`, `rd_out` = 0.
- Minimum load/store latency: 2 cycles. In cycle N, IDLE decides and `busy_out`=1. In cycle N+1, `data_req_out`=1; if ack arrives in N+1, the writeback register updates at the end of N+1.
- Non-memory instructions: 1 cycle, `busy_out`=0.
- `data_req_out` drops the cycle after ack. There are no back-to-back requests without passing through IDLE.
- Reset mid-WAIT: request deasserts immediately (async). The bus must tolerate abandonment.

## Test plan
- Load double at 0x1000, ack after 3 cycles with rdata 0x1122334455667788 → `busy_out` high 4 cycles, `rd_value_out`=0x1122334455667788, `valid_out`=1.
- Store byte 0xAB at 0x2005 → addr 0x2000, strb 0x20, wdata byte 5 = 0xAB, `data_we_out`=1.
- Load half at 0x3006 with rdata 0x8001_0000_0000_0000, sign vs zero extend → 0xFFFFFFFFFFFF8001 / 0x8001.
- Load word at 0x4002 → no `data_req_out`, `misaligned_out`=1 one cycle, `rd_write_out`=0.
- Branch op 2, nz=1, predicted 0, target 0x500 → `redirect_out`=1, pc 0x500. Op 3, nz=1, predicted 1, pc 0x600 → redirect to 0x604.
- Ack while `stall_in`=1 → state DONE, single bus request only, result delivered when stall releases.

Source files
------------

// File: rtl/memory_access.sv
// Memory-access pipeline stage: loads/stores/fences over a single-outstanding
// request/ack data bus, branch resolution, and the registered writeback bundle.
module memory_access (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_in,
  input  logic        flush_in,
  input  logic        valid_in,
  input  logic        branch_predicted_taken_in,
  input  logic        alu_non_zero_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic        mem_fence_in,
  input  logic [2:0]  mem_width_in,
  input  logic        mem_zero_extend_in,
  input  logic [2:0]  branch_op_in,
  input  logic [8:0]  rd_in,
  input  logic        rd_write_in,
  input  logic [63:0] pc_in,
  input  logic [63:0] result_in,
  input  logic [63:0] rs2_value_in,
  input  logic [63:0] branch_pc_in,
  output logic        data_req_out,
  output logic        data_we_out,
  output logic [63:0] data_addr_out,
  output logic [63:0] data_wdata_out,
  output logic [7:0]  data_strb_out,
  input  logic        data_ack_in,
  input  logic [63:0] data_rdata_in,
  output logic        busy_out,
  output logic        redirect_out,
  output logic [63:0] redirect_pc_out,
  output logic        misaligned_out,
  output logic        valid_out,
  output logic        rd_write_out,
  output logic [8:0]  rd_out,
  output logic [63:0] rd_value_out
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t      state_q, state_d;
  logic        access, aligned, launch, misalign;
  logic [1:0]  width;
  logic [2:0]  lane;
  logic [63:0] st_data;
  logic [7:0]  st_strb;
  logic        taken;

  logic        is_read_q, zext_q, flushed_q;
  logic [1:0]  width_q;
  logic [2:0]  lane_q;
  logic [63:0] load_data_q;
  logic [63:0] shifted, load_ext, wb_value;
  logic        wb_en, kill;

  // Width codes 4-7 behave as double.
  assign width  = mem_width_in[2] ? 2'd3 : mem_width_in[1:0];
  assign lane   = result_in[2:0];
  assign access = valid_in & (mem_read_in | mem_write_in) & ~flush_in;

  always_comb begin
    aligned = 1'b1;
    unique case (width)
      2'd0: aligned = 1'b1;
      2'd1: aligned = ~lane[0];
      2'd2: aligned = (lane[1:0] == 2'b00);
      2'd3: aligned = (lane == 3'b000);
    endcase
  end

  // A fence never touches the bus, so it neither launches nor faults.
  assign launch   = (state_q == IDLE) & access & aligned & ~mem_fence_in;
  assign misalign = (state_q == IDLE) & access & ~aligned & ~mem_fence_in;
  assign busy_out = launch | ((state_q == WAIT) & ~data_ack_in);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (launch) state_d = WAIT;
      WAIT: if (data_ack_in) state_d = stall_in ? DONE : IDLE;
      DONE: if (!stall_in) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    st_data = rs2_value_in;
    st_strb = 8'hFF;
    unique case (width)
      2'd0: begin st_data = {8{rs2_value_in[7:0]}};  st_strb = 8'h01 << lane; end
      2'd1: begin st_data = {4{rs2_value_in[15:0]}}; st_strb = 8'h03 << lane; end
      2'd2: begin st_data = {2{rs2_value_in[31:0]}}; st_strb = 8'h0F << lane; end
      2'd3: begin st_data = rs2_value_in;            st_strb = 8'hFF;         end
    endcase
  end

  assign shifted = data_rdata_in >> {lane_q, 3'b000};

  always_comb begin
    load_ext = shifted;
    unique case (width_q)
      2'd0: load_ext = zext_q ? {56'd0, shifted[7:0]}  : {{56{shifted[7]}},  shifted[7:0]};
      2'd1: load_ext = zext_q ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
      2'd2: load_ext = zext_q ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
      2'd3: load_ext = shifted;
    endcase
  end

  always_comb begin
    taken = (branch_op_in == 3'd1) |
            ((branch_op_in == 3'd2) & alu_non_zero_in) |
            ((branch_op_in == 3'd3) & ~alu_non_zero_in);
  end

  assign redirect_out    = valid_in & ~flush_in & (branch_op_in != 3'd0) &
                           (taken != branch_predicted_taken_in);
  assign redirect_pc_out = taken ? branch_pc_in : pc_in + 64'd4;

  // Loaded data comes straight off the bus on ack, or from the capture
  // register when the stage was stalled at ack time (DONE).
  always_comb begin
    wb_value = result_in;
    if (state_q == WAIT && is_read_q)      wb_value = load_ext;
    else if (state_q == DONE && is_read_q) wb_value = load_data_q;
  end

  assign wb_en = ~stall_in & ~busy_out;
  assign kill  = flush_in | flushed_q | misalign;
  assign data_req_out = (state_q == WAIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      data_we_out    <= 1'b0;
      data_addr_out  <= '0;
      data_wdata_out <= '0;
      data_strb_out  <= '0;
      is_read_q      <= 1'b0;
      zext_q         <= 1'b0;
      width_q        <= '0;
      lane_q         <= '0;
      load_data_q    <= '0;
      flushed_q      <= 1'b0;
      misaligned_out <= 1'b0;
      valid_out      <= 1'b0;
      rd_write_out   <= 1'b0;
      rd_out         <= '0;
      rd_value_out   <= '0;
    end else begin
      state_q        <= state_d;
      misaligned_out <= misalign & ~stall_in;
      if (launch) begin
        data_we_out    <= mem_write_in & ~mem_read_in;
        data_addr_out  <= {result_in[63:3], 3'b000};
        data_wdata_out <= st_data;
        data_strb_out  <= st_strb;
        is_read_q      <= mem_read_in;
        zext_q         <= mem_zero_extend_in;
        width_q        <= width;
        lane_q         <= lane;
      end
      if (state_q == WAIT && data_ack_in) load_data_q <= load_ext;
      // Flush seen at any point of an in-flight access discards its result.
      if (state_d == IDLE || state_q == IDLE) flushed_q <= 1'b0;
      else                                     flushed_q <= flushed_q | flush_in;
      if (wb_en) begin
        valid_out    <= valid_in & ~kill;
        rd_write_out <= rd_write_in & ~kill;
        rd_out       <= rd_in;
        rd_value_out <= wb_value;
      end
    end
  end

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: bench acts as the data-bus responder.
module tb_memory_access;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_in, flush_in, valid_in, branch_predicted_taken_in, alu_non_zero_in;
  logic        mem_read_in, mem_write_in, mem_fence_in, mem_zero_extend_in;
  logic [2:0]  mem_width_in, branch_op_in;
  logic [8:0]  rd_in;
  logic        rd_write_in;
  logic [63:0] pc_in, result_in, rs2_value_in, branch_pc_in;
  logic        data_req_out, data_we_out;
  logic [63:0] data_addr_out, data_wdata_out;
  logic [7:0]  data_strb_out;
  logic        data_ack_in;
  logic [63:0] data_rdata_in;
  logic        busy_out, redirect_out, misaligned_out, valid_out, rd_write_out;
  logic [63:0] redirect_pc_out, rd_value_out;
  logic [8:0]  rd_out;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  memory_access dut (
    .clk(clk), .rst_n(rst_n), .stall_in(stall_in), .flush_in(flush_in),
    .valid_in(valid_in), .branch_predicted_taken_in(branch_predicted_taken_in),
    .alu_non_zero_in(alu_non_zero_in), .mem_read_in(mem_read_in),
    .mem_write_in(mem_write_in), .mem_fence_in(mem_fence_in),
    .mem_width_in(mem_width_in), .mem_zero_extend_in(mem_zero_extend_in),
    .branch_op_in(branch_op_in), .rd_in(rd_in), .rd_write_in(rd_write_in),
    .pc_in(pc_in), .result_in(result_in), .rs2_value_in(rs2_value_in),
    .branch_pc_in(branch_pc_in), .data_req_out(data_req_out),
    .data_we_out(data_we_out), .data_addr_out(data_addr_out),
    .data_wdata_out(data_wdata_out), .data_strb_out(data_strb_out),
    .data_ack_in(data_ack_in), .data_rdata_in(data_rdata_in),
    .busy_out(busy_out), .redirect_out(redirect_out),
    .redirect_pc_out(redirect_pc_out), .misaligned_out(misaligned_out),
    .valid_out(valid_out), .rd_write_out(rd_write_out), .rd_out(rd_out),
    .rd_value_out(rd_value_out)
  );

  task automatic clear_inputs();
    stall_in = 0; flush_in = 0; valid_in = 0; branch_predicted_taken_in = 0;
    alu_non_zero_in = 0; mem_read_in = 0; mem_write_in = 0; mem_fence_in = 0;
    mem_width_in = 0; mem_zero_extend_in = 0; branch_op_in = 0; rd_in = 0;
    rd_write_in = 0; pc_in = 0; result_in = 0; rs2_value_in = 0; branch_pc_in = 0;
    data_ack_in = 0; data_rdata_in = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    clear_inputs();
    @(negedge clk);
    tests++;
    if ({data_req_out, data_we_out, busy_out, misaligned_out, valid_out, rd_write_out} !== 6'b0 ||
        data_addr_out !== 64'd0 || data_wdata_out !== 64'd0 || data_strb_out !== 8'd0 ||
        rd_out !== 9'd0 || rd_value_out !== 64'd0) begin
      fails++;
      $display("FAIL reset_outputs: got req=%b we=%b busy=%b mis=%b v=%b rdw=%b addr=%h strb=%h rd=%h val=%h, want all zero",
               data_req_out, data_we_out, busy_out, misaligned_out, valid_out, rd_write_out,
               data_addr_out, data_strb_out, rd_out, rd_value_out);
    end
    @(posedge clk); #1 rst_n = 1;
    step();
  endtask

  task automatic test_load_double();
    int busy_cnt = 0;
    valid_in = 1; mem_read_in = 1; mem_width_in = 3; result_in = 64'h1000;
    rd_in = 9'd5; rd_write_in = 1;
    @(negedge clk);
    if (busy_out) busy_cnt++;
    tests++;
    if (data_req_out !== 1'b0) begin fails++; $display("FAIL ld_no_req_in_idle: got %b want 0", data_req_out); end
    step();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (busy_out) busy_cnt++;
      tests++;
      if (data_req_out !== 1'b1 || data_addr_out !== 64'h1000 || data_we_out !== 1'b0) begin
        fails++;
        $display("FAIL ld_wait_%0d: got req=%b addr=%h we=%b want 1 1000 0", k, data_req_out, data_addr_out, data_we_out);
      end
      step();
    end
    data_ack_in = 1; data_rdata_in = 64'h1122334455667788;
    @(negedge clk);
    if (busy_out) busy_cnt++;
    tests++;
    if (busy_cnt != 4) begin fails++; $display("FAIL ld_busy_cycles: got %0d want 4", busy_cnt); end
    step();
    data_ack_in = 0; clear_inputs();
    tests++;
    if (valid_out !== 1'b1 || rd_write_out !== 1'b1 || rd_out !== 9'd5 ||
        rd_value_out !== 64'h1122334455667788 || data_req_out !== 1'b0) begin
      fails++;
      $display("FAIL ld_writeback: got v=%b rdw=%b rd=%0d val=%h req=%b want 1 1 5 1122334455667788 0",
               valid_out, rd_write_out, rd_out, rd_value_out, data_req_out);
    end
    step();
  endtask

  task automatic test_store_byte();
    valid_in = 1; mem_write_in = 1; mem_width_in = 0; result_in = 64'h2005;
    rs2_value_in = 64'h00000000000000AB;
    step();
    data_ack_in = 1;
    @(negedge clk);
    tests++;
    if (data_req_out !== 1'b1 || data_we_out !== 1'b1 || data_addr_out !== 64'h2000 ||
        data_strb_out !== 8'h20 || data_wdata_out[47:40] !== 8'hAB) begin
      fails++;
      $display("FAIL st_byte_bus: got req=%b we=%b addr=%h strb=%h wdata=%h want 1 1 2000 20 byte5=ab",
               data_req_out, data_we_out, data_addr_out, data_strb_out, data_wdata_out);
    end
    step();
    clear_inputs();
    tests++;
    if (valid_out !== 1'b1 || data_req_out !== 1'b0) begin
      fails++; $display("FAIL st_byte_done: got v=%b req=%b want 1 0", valid_out, data_req_out);
    end
    step();
  endtask

  task automatic test_load_half();
    logic [63:0] exp [2];
    exp[0] = 64'hFFFFFFFFFFFF8001;
    exp[1] = 64'h0000000000008001;
    for (int i = 0; i < 2; i++) begin
      valid_in = 1; mem_read_in = 1; mem_width_in = 1; result_in = 64'h3006;
      mem_zero_extend_in = (i == 1); rd_in = 9'd7; rd_write_in = 1;
      step();
      data_ack_in = 1; data_rdata_in = 64'h8001000000000000;
      @(negedge clk);
      tests++;
      if (data_addr_out !== 64'h3000 || data_strb_out !== 8'hC0) begin
        fails++; $display("FAIL lh_bus_%0d: got addr=%h strb=%h want 3000 c0", i, data_addr_out, data_strb_out);
      end
      step();
      clear_inputs();
      tests++;
      if (rd_value_out !== exp[i] || valid_out !== 1'b1) begin
        fails++; $display("FAIL lh_value_%0d: got %h v=%b want %h v=1", i, rd_value_out, valid_out, exp[i]);
      end
      step();
    end
  endtask

  task automatic test_misaligned();
    valid_in = 1; mem_read_in = 1; mem_width_in = 2; result_in = 64'h4002;
    rd_in = 9'd3; rd_write_in = 1;
    @(negedge clk);
    tests++;
    if (busy_out !== 1'b0) begin fails++; $display("FAIL mis_busy: got %b want 0", busy_out); end
    step();
    clear_inputs();
    tests++;
    if (misaligned_out !== 1'b1 || rd_write_out !== 1'b0 || valid_out !== 1'b0 || data_req_out !== 1'b0) begin
      fails++;
      $display("FAIL mis_pulse: got mis=%b rdw=%b v=%b req=%b want 1 0 0 0", misaligned_out, rd_write_out, valid_out, data_req_out);
    end
    step();
    tests++;
    if (misaligned_out !== 1'b0 || data_req_out !== 1'b0) begin
      fails++; $display("FAIL mis_one_cycle: got mis=%b req=%b want 0 0", misaligned_out, data_req_out);
    end
  endtask

  task automatic test_branch();
    valid_in = 1; branch_op_in = 2; alu_non_zero_in = 1; branch_predicted_taken_in = 0;
    branch_pc_in = 64'h500; pc_in = 64'h4F0; result_in = 64'h99; rd_in = 9'd1; rd_write_in = 1;
    #1;
    tests++;
    if (redirect_out !== 1'b1 || redirect_pc_out !== 64'h500 || busy_out !== 1'b0) begin
      fails++; $display("FAIL br_op2: got redir=%b pc=%h busy=%b want 1 500 0", redirect_out, redirect_pc_out, busy_out);
    end
    step();
    tests++;
    if (valid_out !== 1'b1 || rd_value_out !== 64'h99 || rd_write_out !== 1'b1) begin
      fails++; $display("FAIL alu_writeback: got v=%b val=%h rdw=%b want 1 99 1", valid_out, rd_value_out, rd_write_out);
    end
    branch_op_in = 3; alu_non_zero_in = 1; branch_predicted_taken_in = 1; pc_in = 64'h600;
    #1;
    tests++;
    if (redirect_out !== 1'b1 || redirect_pc_out !== 64'h604) begin
      fails++; $display("FAIL br_op3: got redir=%b pc=%h want 1 604", redirect_out, redirect_pc_out);
    end
    branch_op_in = 1; branch_predicted_taken_in = 1;
    #1;
    tests++;
    if (redirect_out !== 1'b0) begin fails++; $display("FAIL br_correct_pred: got %b want 0", redirect_out); end
    branch_predicted_taken_in = 0; flush_in = 1;
    #1;
    tests++;
    if (redirect_out !== 1'b0) begin fails++; $display("FAIL br_flushed: got %b want 0", redirect_out); end
    clear_inputs();
    step();
  endtask

  task automatic test_stall_ack();
    int reqs = 0;
    valid_in = 1; mem_read_in = 1; mem_width_in = 3; result_in = 64'h1008;
    rd_in = 9'd9; rd_write_in = 1; stall_in = 1;
    step();
    data_ack_in = 1; data_rdata_in = 64'hDEADBEEFCAFEF00D;
    @(negedge clk);
    if (data_req_out) reqs++;
    step();
    data_ack_in = 0; data_rdata_in = 64'h0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (data_req_out) reqs++;
      tests++;
      if (busy_out !== 1'b0 || valid_out !== 1'b0) begin
        fails++; $display("FAIL stall_done_%0d: got busy=%b v=%b want 0 0", k, busy_out, valid_out);
      end
      step();
    end
    stall_in = 0;
    step();
    clear_inputs();
    tests++;
    if (valid_out !== 1'b1 || rd_value_out !== 64'hDEADBEEFCAFEF00D || rd_out !== 9'd9) begin
      fails++; $display("FAIL stall_release: got v=%b val=%h rd=%0d want 1 deadbeefcafef00d 9", valid_out, rd_value_out, rd_out);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      if (data_req_out) reqs++;
      step();
    end
    tests++;
    if (reqs != 1) begin fails++; $display("FAIL stall_single_req: got %0d request cycles want 1", reqs); end
  endtask

  task automatic test_flush_wait();
    valid_in = 1; mem_read_in = 1; mem_width_in = 3; result_in = 64'h1010;
    rd_in = 9'd4; rd_write_in = 1;
    step();
    flush_in = 1;
    step();
    flush_in = 0; data_ack_in = 1; data_rdata_in = 64'h5;
    @(negedge clk);
    tests++;
    if (data_req_out !== 1'b1) begin fails++; $display("FAIL flush_keeps_req: got %b want 1", data_req_out); end
    step();
    clear_inputs();
    tests++;
    if (valid_out !== 1'b0 || rd_write_out !== 1'b0 || data_req_out !== 1'b0) begin
      fails++; $display("FAIL flush_discard: got v=%b rdw=%b req=%b want 0 0 0", valid_out, rd_write_out, data_req_out);
    end
    step();
  endtask

  task automatic test_reset_mid_wait();
    valid_in = 1; mem_write_in = 1; mem_width_in = 3; result_in = 64'h1018;
    step();
    tests++;
    if (data_req_out !== 1'b1) begin fails++; $display("FAIL rst_mid_pre: got %b want 1", data_req_out); end
    #2 rst_n = 0;
    #1;
    tests++;
    if (data_req_out !== 1'b0 || data_we_out !== 1'b0) begin
      fails++; $display("FAIL rst_mid_async: got req=%b we=%b want 0 0", data_req_out, data_we_out);
    end
    clear_inputs();
    step();
    rst_n = 1;
    step();
  endtask

  initial begin
    test_reset();
    test_load_double();
    test_store_byte();
    test_load_half();
    test_misaligned();
    test_branch();
    test_stall_ack();
    test_flush_wait();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
